// File: rtl/rns_to_int_mrc.sv
`default_nettype none
// ============================================================================
//  Module     : rns_to_int_mrc
//  Description: Iterative mixed-radix reverse converter from a packed
//               4-modulus RNS word {r4,r3,r2,r1} to a 32-bit integer, one
//               mixed-radix digit per cycle, valid/ready on both sides.
//               Optional macro RNS_RANGE_CHECK_EN adds residue range checks
//               and drives out_err.
//  Revision   : 1.0 - initial release
// ============================================================================
module rns_to_int_mrc #(
   parameter int unsigned M1         = 233,
   parameter int unsigned M2         = 239,
   parameter int unsigned M3         = 241,
   parameter int unsigned M4         = 251,
   parameter bit          SIGNED_OUT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        out_err
);

   // Smallest i with a*i == 1 (mod m); evaluated at elaboration only.
   function automatic int unsigned mod_inv(input int unsigned a, input int unsigned m);
      int unsigned r;
      r = 0;
      for (int unsigned i = 1; i < m; i++) begin
         if ((r == 0) && ((((a % m) * i) % m) == 32'd1)) r = i;
      end
      return r;
   endfunction

   localparam int unsigned C_INV2 = mod_inv(M1, M2);
   localparam int unsigned C_INV3 = mod_inv(M1 * M2, M3);
   localparam int unsigned C_INV4 = mod_inv(M1 * M2 * M3, M4);
   localparam logic [31:0] C_W2   = 32'(M1);
   localparam logic [31:0] C_W3   = 32'(M1 * M2);
   localparam logic [31:0] C_W4   = 32'(M1 * M2 * M3);
   localparam logic [63:0] C_M    = 64'(M1) * 64'(M2) * 64'(M3) * 64'(M4);
   localparam logic [31:0] C_M32  = 32'(C_M);
   localparam logic [31:0] C_HALF = 32'((C_M - 64'd1) / 64'd2);

   // Mixed-radix digit: ((r - X mod m) * inv) mod m, with m added first so
   // the difference never goes negative.
   function automatic logic [7:0] digit(input logic [7:0] r, input logic [31:0] xv,
                                        input int unsigned m, input int unsigned inv);
      logic [8:0]  diff;
      logic [7:0]  d;
      logic [15:0] p;
      diff = 9'(r) + 9'(m) - 9'(xv % m);
      d    = 8'(diff % 9'(m));
      p    = 16'(d) * 16'(inv);
      return 8'(p % 16'(m));
   endfunction

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_D2   = 3'd1,
      S_D3   = 3'd2,
      S_D4   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_r2, r_r3, r_r4;
   logic [31:0] r_x, r_y;
   logic        r_err, r_out_err;
   logic [7:0]  w_l1, w_l2, w_l3, w_l4;
   logic        w_err;
   logic [7:0]  w_a2, w_a3, w_a4;
   logic [31:0] w_xfin, w_yfin;

`ifdef RNS_RANGE_CHECK_EN
   // Flag non-canonical residues and reduce them so conversion still runs.
   assign w_err = (x[7:0]   >= 8'(M1)) | (x[15:8]  >= 8'(M2)) |
                  (x[23:16] >= 8'(M3)) | (x[31:24] >= 8'(M4));
   assign w_l1  = x[7:0]   % 8'(M1);
   assign w_l2  = x[15:8]  % 8'(M2);
   assign w_l3  = x[23:16] % 8'(M3);
   assign w_l4  = x[31:24] % 8'(M4);
`else
   assign w_err = 1'b0;
   assign w_l1  = x[7:0];
   assign w_l2  = x[15:8];
   assign w_l3  = x[23:16];
   assign w_l4  = x[31:24];
`endif

   assign w_a2   = digit(r_r2, r_x, M2, C_INV2);
   assign w_a3   = digit(r_r3, r_x, M3, C_INV3);
   assign w_a4   = digit(r_r4, r_x, M4, C_INV4);
   assign w_xfin = r_x + 32'(w_a4) * C_W4;
   assign w_yfin = (SIGNED_OUT && (w_xfin > C_HALF)) ? (w_xfin - C_M32) : w_xfin;

   assign y       = r_y;
   assign out_err = r_out_err;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_D2;
         end
         S_D2:   w_state_nxt = S_D3;
         S_D3:   w_state_nxt = S_D4;
         S_D4:   w_state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Residue latch, running X accumulation and result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_r2      <= '0;
         r_r3      <= '0;
         r_r4      <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_err     <= 1'b0;
         r_out_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_r2  <= w_l2;
               r_r3  <= w_l3;
               r_r4  <= w_l4;
               r_x   <= {24'd0, w_l1};
               r_err <= w_err;
            end
            S_D2: r_x <= r_x + 32'(w_a2) * C_W2;
            S_D3: r_x <= r_x + 32'(w_a3) * C_W3;
            S_D4: begin
               r_x       <= w_xfin;
               r_y       <= w_yfin;
               r_out_err <= r_err;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
